// File: rtl/gamepad_pmod_pkg.sv
// Shared definitions for the Gamepad Pmod transmit and receive drivers.
// Contents:
//   gp_state_t     - transmitter FSM states
//   GP_BUTTONS     - buttons per controller
//   GP_FRAME_BITS  - bits per frame (two controllers)
//   BTN_*          - bit index of each button inside a 12-bit controller word
package gamepad_pmod_pkg;

  localparam int GP_BUTTONS    = 12;
  localparam int GP_FRAME_BITS = 24;

  // Button order inside a controller word, MSB first:
  // {b, y, select, start, up, down, left, right, a, x, l, r}
  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BIT_LO = 3'd1,
    BIT_HI = 3'd2,
    LATCH  = 3'd3,
    GAP    = 3'd4
  } gp_state_t;

endpackage

// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod transmitter: serialises {buttons2, buttons1} MSB first on
// pmod_data/pmod_clk, then pulses pmod_latch, then idles for one gap phase.
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   buttons1, buttons2  - controller button vectors (1 = pressed)
//   send                - frame request, taken only while busy is low
//   busy                - a frame is in progress
//   done                - one-cycle pulse as busy falls
//   pmod_latch, pmod_clk, pmod_data - protocol lines
// All outputs come straight from flops.
module gamepad_pmod_tx
  import gamepad_pmod_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = GP_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GP_BUTTONS-1:0] buttons1,
  input  logic [GP_BUTTONS-1:0] buttons2,
  input  logic                  send,
  output logic                  busy,
  output logic                  done,
  output logic                  pmod_latch,
  output logic                  pmod_clk,
  output logic                  pmod_data
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LOAD = PW'(CLK_DIV - 1);
  localparam logic [4:0]    BIT_LOAD   = 5'(FRAME_BITS - 1);

  gp_state_t             state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [4:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  busy_d, done_d, latch_d, pclk_d, data_d;
  logic                  phase_end;

  assign phase_end = (phase_q == '0);

  // State register together with the phase counter, bit counter and
  // shift register, which all advance in lockstep with the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic. The shift happens on the BIT_HI -> BIT_LO edge so the
  // new data bit appears in the same cycle pmod_clk falls. The phase counter
  // reloads on every state change and otherwise counts down to zero.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (send) begin
          state_d = BIT_LO;
          shreg_d = FRAME_BITS'({buttons2, buttons1});
          bit_d   = BIT_LOAD;
        end
      end
      BIT_LO: if (phase_end) state_d = BIT_HI;
      BIT_HI: begin
        if (phase_end) begin
          if (bit_q == 5'd0) begin
            state_d = LATCH;
          end else begin
            state_d = BIT_LO;
            bit_d   = bit_q - 5'd1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      LATCH:   if (phase_end) state_d = GAP;
      GAP:     if (phase_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      phase_d = (state_d == IDLE) ? '0 : PHASE_LOAD;
    end else if (!phase_end) begin
      phase_d = phase_q - PW'(1);
    end
  end

  // Output decode from the next state, registered below so every output
  // is a flop that lines up with the state it belongs to.
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == GAP) && (state_d == IDLE);
    latch_d = (state_d == LATCH);
    pclk_d  = (state_d == BIT_HI);
    data_d  = 1'b0;
    if (state_d == BIT_LO || state_d == BIT_HI) begin
      data_d = shreg_d[FRAME_BITS-1];
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pmod_latch <= 1'b0;
      pmod_clk   <= 1'b0;
      pmod_data  <= 1'b0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      pmod_latch <= latch_d;
      pmod_clk   <= pclk_d;
      pmod_data  <= data_d;
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Directed testbench for gamepad_pmod_tx. Instance dut_a runs CLK_DIV=2,
// instance dut_b runs CLK_DIV=1 for the back-to-back frame test. A small
// receiver model samples pmod_data on each rising pmod_clk.
module tb_gamepad_pmod_tx;
  import gamepad_pmod_pkg::*;

  logic        clk;
  logic        reset;

  logic [11:0] b1_a, b2_a;
  logic        send_a, busy_a, done_a, latch_a, pclk_a, data_a;
  logic [11:0] b1_b, b2_b;
  logic        send_b, busy_b, done_b, latch_b, pclk_b, data_b;

  int          cmp_count;
  int          err_count;

  // Results of the most recent observeFrame call.
  logic [23:0] rx_word;
  int          rx_edges, busy_cyc, done_cnt, done_at;
  int          latch_cyc, latch_pulses, first_rise, hold_viol;
  logic        busy_first, data_first;

  gamepad_pmod_tx #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .buttons1(b1_a), .buttons2(b2_a),
    .send(send_a), .busy(busy_a), .done(done_a),
    .pmod_latch(latch_a), .pmod_clk(pclk_a), .pmod_data(data_a)
  );

  gamepad_pmod_tx #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .buttons1(b1_b), .buttons2(b2_b),
    .send(send_b), .busy(busy_b), .done(done_b),
    .pmod_latch(latch_b), .pmod_clk(pclk_b), .pmod_data(data_b)
  );

  // 10-unit system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    cmp_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Loads the buttons of dut_a and pulses send for one cycle. Returns at the
  // falling edge of the cycle after acceptance.
  task automatic applyStimulus(input logic [11:0] b2, input logic [11:0] b1);
    @(negedge clk);
    b1_a   = b1;
    b2_a   = b2;
    send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
  endtask

  // Watches dut_a for a fixed number of cycles, acting as the receiver.
  // Cycle k=1 is the cycle after acceptance. At k==poke_at the buttons are
  // inverted and send is pulsed, which the busy DUT must ignore.
  task automatic observeFrame(input int cycles, input int poke_at);
    logic prev_pclk, prev_data, prev_latch;
    rx_word = '0; rx_edges = 0; busy_cyc = 0; done_cnt = 0; done_at = 0;
    latch_cyc = 0; latch_pulses = 0; first_rise = 0; hold_viol = 0;
    prev_pclk = 1'b0; prev_data = data_a; prev_latch = 1'b0;
    busy_first = busy_a;
    data_first = data_a;
    for (int k = 1; k <= cycles; k++) begin
      if (pclk_a && !prev_pclk) begin
        rx_word = {rx_word[22:0], data_a};
        rx_edges++;
        if (first_rise == 0) first_rise = k;
      end
      if (pclk_a && prev_pclk && (data_a !== prev_data)) hold_viol++;
      if (busy_a) busy_cyc++;
      if (latch_a) latch_cyc++;
      if (latch_a && !prev_latch) latch_pulses++;
      if (done_a) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      prev_pclk = pclk_a; prev_data = data_a; prev_latch = latch_a;
      if (k == poke_at) begin
        b1_a   = ~b1_a;
        b2_a   = ~b2_a;
        send_a = 1'b1;
      end else begin
        send_a = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Main directed sequence.
  initial begin
    int          nz;
    int          done_pos [3];
    int          dn, edges_b;
    logic [23:0] rx_b;
    logic        prev_pclk_b, busy51, busy52;

    cmp_count = 0;
    err_count = 0;
    reset = 1'b1;
    b1_a = '0; b2_a = '0; send_a = 1'b0;
    b1_b = '0; b2_b = '0; send_b = 1'b0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs_a", {27'd0, busy_a, done_a, latch_a, pclk_a, data_a}, 32'd0);
    checkOutput("reset_outputs_b", {27'd0, busy_b, done_b, latch_b, pclk_b, data_b}, 32'd0);
    reset = 1'b0;
    nz = 0;
    repeat (20) begin
      @(negedge clk);
      if ({busy_a, done_a, latch_a, pclk_a, data_a,
           busy_b, done_b, latch_b, pclk_b, data_b} != 10'd0) nz++;
    end
    checkOutput("idle_nonzero_cycles", nz, 0);

    // Basic frame, CLK_DIV=2: 24 bits, 2-cycle latch, busy for 100 cycles.
    applyStimulus(12'h000, 12'hA5C);
    observeFrame(130, 0);
    checkOutput("f1_busy_first", {31'd0, busy_first}, 32'd1);
    checkOutput("f1_first_rise", first_rise, 3);
    checkOutput("f1_edges", rx_edges, 24);
    checkOutput("f1_rx_word", {8'd0, rx_word}, 32'h000A5C);
    checkOutput("f1_latch_pulses", latch_pulses, 1);
    checkOutput("f1_latch_cycles", latch_cyc, 2);
    checkOutput("f1_busy_cycles", busy_cyc, 100);
    checkOutput("f1_done_count", done_cnt, 1);
    checkOutput("f1_done_at", done_at, 101);
    checkOutput("f1_data_hold", hold_viol, 0);

    // Loopback: b and r pressed on controller 1.
    applyStimulus(12'h000, 12'h801);
    observeFrame(110, 0);
    checkOutput("lb_btn_b", {31'd0, rx_word[BTN_B]}, 32'd1);
    checkOutput("lb_btn_r", {31'd0, rx_word[BTN_R]}, 32'd1);
    checkOutput("lb_ctrl1", {20'd0, rx_word[11:0]}, 32'h801);
    checkOutput("lb_ctrl2", {20'd0, rx_word[23:12]}, 32'h000);

    // Inputs change and send pulses mid-frame: content fixed at accept.
    applyStimulus(12'hC35, 12'h1E7);
    observeFrame(130, 20);
    checkOutput("mid_data_first", {31'd0, data_first}, 32'd1);
    checkOutput("mid_rx_word", {8'd0, rx_word}, 32'hC351E7);
    checkOutput("mid_edges", rx_edges, 24);
    checkOutput("mid_done_count", done_cnt, 1);
    checkOutput("mid_busy_cycles", busy_cyc, 100);

    // Reset during bit 10 (its high phase is k=43,44).
    applyStimulus(12'h5F0, 12'h3AA);
    repeat (42) @(negedge clk);
    checkOutput("rst_pre_pclk", {31'd0, pclk_a}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_outputs", {27'd0, busy_a, done_a, latch_a, pclk_a, data_a}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nz = 0;
    repeat (5) begin
      @(negedge clk);
      if ({busy_a, done_a, latch_a, pclk_a, data_a} != 5'd0) nz++;
    end
    checkOutput("rst_stays_quiet", nz, 0);
    applyStimulus(12'h9A3, 12'h46B);
    observeFrame(110, 0);
    checkOutput("rst_new_rx_word", {8'd0, rx_word}, 32'h9A346B);
    checkOutput("rst_new_edges", rx_edges, 24);
    checkOutput("rst_new_done_at", done_at, 101);

    // Back-to-back frames on dut_b (CLK_DIV=1) with send held high.
    @(negedge clk);
    b1_b = 12'h00F;
    b2_b = 12'h0F0;
    send_b = 1'b1;
    @(negedge clk);
    dn = 0; edges_b = 0; rx_b = '0; prev_pclk_b = 1'b0;
    busy51 = 1'b1; busy52 = 1'b0;
    done_pos[0] = 0; done_pos[1] = 0; done_pos[2] = 0;
    for (int k = 1; k <= 200; k++) begin
      if (pclk_b && !prev_pclk_b) begin
        rx_b = {rx_b[22:0], data_b};
        edges_b++;
      end
      prev_pclk_b = pclk_b;
      if (done_b) begin
        if (dn < 3) done_pos[dn] = k;
        dn++;
      end
      if (k == 51) busy51 = busy_b;
      if (k == 52) busy52 = busy_b;
      if (k == 110) send_b = 1'b0;
      @(negedge clk);
    end
    checkOutput("b2b_done1", done_pos[0], 51);
    checkOutput("b2b_done2", done_pos[1], 102);
    checkOutput("b2b_done3", done_pos[2], 153);
    checkOutput("b2b_done_count", dn, 3);
    checkOutput("b2b_busy_at_done", {31'd0, busy51}, 32'd0);
    checkOutput("b2b_busy_after", {31'd0, busy52}, 32'd1);
    checkOutput("b2b_edges", edges_b, 72);
    checkOutput("b2b_rx_word", {8'd0, rx_b}, 32'h0F000F);
    checkOutput("b2b_final_idle", {30'd0, busy_b, latch_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
